// File: rtl/pdp8_sequencer_gen_if.sv
// ---------------------------------------------------------------------------
// pdp8_sequencer_gen_if
//
// Purpose : groups the control inputs and the timing outputs of the PDP-8
//           major-state/timing generator into one bundle.
//
// Parameters
//   NPHASE : number of execute phases (width of ck / stb)
//   CNT_W  : width of the completed-instruction counter
//
// Signals
//   startstop, sst   run/stop and single-step buttons (rising-edge active)
//   HALT, DONE       halt request and OR of handler done lines
//   SEQTYPE          {PPIND,IND} from IR decode
//   brk_req          data-break request (level)
//   brk_ack          one-clock data-break grant
//   ck*/stb*         major-state levels and strobes
//   ck/stb           execute-phase levels and strobes, one-hot
//   running, seq_err CPU running / sticky phase-overrun flag
//   icount           completed-instruction count (zero unless enabled)
//
// Modports
//   master : the sequencer (drives the timing outputs)
//   slave  : the CPU datapath / environment (drives the control inputs)
// ---------------------------------------------------------------------------
interface pdp8_sequencer_gen_if #(
    parameter int NPHASE = 6,
    parameter int CNT_W  = 16
);
    logic              startstop;
    logic              sst;
    logic              HALT;
    logic              DONE;
    logic [1:0]        SEQTYPE;
    logic              brk_req;
    logic              brk_ack;
    logic              ckFetch;
    logic              ckAuto1;
    logic              ckAuto2;
    logic              ckInd;
    logic              ckBrk;
    logic              stbFetch;
    logic              stbAuto1;
    logic              stbAuto2;
    logic              stbInd;
    logic              stbBrk;
    logic [NPHASE-1:0] ck;
    logic [NPHASE-1:0] stb;
    logic              running;
    logic              seq_err;
    logic [CNT_W-1:0]  icount;

    modport master (
        input  startstop, sst, HALT, DONE, SEQTYPE, brk_req,
        output brk_ack,
        output ckFetch, ckAuto1, ckAuto2, ckInd, ckBrk,
        output stbFetch, stbAuto1, stbAuto2, stbInd, stbBrk,
        output ck, stb, running, seq_err, icount
    );

    modport slave (
        output startstop, sst, HALT, DONE, SEQTYPE, brk_req,
        input  brk_ack,
        input  ckFetch, ckAuto1, ckAuto2, ckInd, ckBrk,
        input  stbFetch, stbAuto1, stbAuto2, stbInd, stbBrk,
        input  ck, stb, running, seq_err, icount
    );
endinterface

// File: rtl/pdp8_sequencer_gen.sv
// ---------------------------------------------------------------------------
// pdp8_sequencer_gen
//
// Purpose : parametrised major-state / timing generator for the PDP-8 core.
//           Walks FETCH -> [AUTO1 -> AUTO2 ->] [IND ->] PH0..PH(NPHASE-1),
//           inserts data-break (BRK) cycles between instructions, and flags a
//           phase overrun when no handler reports DONE by the last phase.
//           Every non-IDLE state lasts two clocks: its ck level is high on
//           both, its stb strobe on the second only.
//
// Parameters
//   NPHASE  : execute phases, 2..16
//   BRK_MAX : consecutive break cycles allowed before a fetch is forced, 1..15
//   CNT_W   : width of the instruction counter
//
// Ports
//   CLK     : system clock
//   RESET   : asynchronous active-low reset
//   bus     : pdp8_sequencer_gen_if.master (buttons, HALT/DONE, SEQTYPE,
//             break handshake, ck*/stb* timing, running, seq_err, icount)
//
// Optional feature
//   SEQ_ICOUNT_EN : when defined, icount counts completed instructions
//                   (modulo 2^CNT_W); otherwise icount is tied to zero.
// ---------------------------------------------------------------------------
module pdp8_sequencer_gen #(
    parameter int NPHASE  = 6,
    parameter int BRK_MAX = 4,
    parameter int CNT_W   = 16
) (
    input  logic                        CLK,
    input  logic                        RESET,
    pdp8_sequencer_gen_if.master        bus
);

    localparam int              PH_W    = (NPHASE > 1) ? $clog2(NPHASE) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(NPHASE - 1);
    localparam logic [3:0]      BRK_LIM = 4'(BRK_MAX);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_AUTO1,
        S_AUTO2,
        S_IND,
        S_PH,
        S_BRK
    } state_e;

    state_e          state_q, state_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            half_q, half_d;       // 0 = first clock of a state, 1 = strobe clock
    logic            running_q, running_d;
    logic            stop_req_q, stop_req_d;
    logic            step_q, step_d;
    logic            seq_err_q, seq_err_d;
    logic [3:0]      brk_cnt_q, brk_cnt_d;
    logic            startstop_q, startstop_d;
    logic            sst_q, sst_d;

    logic            ss_edge;
    logic            sst_edge;
    logic            stop_now;
    logic            seq_end;              // instruction or break cycle finished
    logic            instr_end;            // an instruction finished (DONE on a phase strobe)
    logic            go_idle;

    assign ss_edge  = bus.startstop & ~startstop_q;
    assign sst_edge = bus.sst & ~sst_q;

    // A stop request raised on this very clock (button edge, or HALT seen in a
    // phase) must already steer the end-of-instruction decision.
    assign stop_now = stop_req_q
                    | (running_q & ss_edge)
                    | ((state_q == S_PH) & bus.HALT);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets its hold/default value first so that no
        // branch leaves it unassigned, which would otherwise infer a latch.
        state_d     = state_q;
        phase_d     = phase_q;
        half_d      = half_q;
        running_d   = running_q;
        stop_req_d  = stop_req_q;
        step_d      = step_q;
        seq_err_d   = seq_err_q;
        brk_cnt_d   = brk_cnt_q;
        startstop_d = bus.startstop;
        sst_d       = bus.sst;
        seq_end     = 1'b0;
        instr_end   = 1'b0;
        go_idle     = 1'b0;

        if (running_q && ss_edge) begin
            stop_req_d = 1'b1;
        end
        if ((state_q == S_PH) && bus.HALT) begin
            stop_req_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (ss_edge) begin
                    running_d = 1'b1;
                    seq_err_d = 1'b0;
                    state_d   = S_FETCH;
                    half_d    = 1'b0;
                end else if (sst_edge) begin
                    running_d = 1'b1;
                    step_d    = 1'b1;
                    state_d   = S_FETCH;
                    half_d    = 1'b0;
                end
            end
            default: begin
                if (!half_q) begin
                    half_d = 1'b1;
                end else begin
                    half_d = 1'b0;
                    unique case (state_q)
                        S_FETCH: begin
                            if (bus.SEQTYPE[1]) begin
                                state_d = S_AUTO1;
                            end else if (bus.SEQTYPE[0]) begin
                                state_d = S_IND;
                            end else begin
                                state_d = S_PH;
                                phase_d = '0;
                            end
                        end
                        S_AUTO1: state_d = S_AUTO2;
                        S_AUTO2: state_d = S_IND;
                        S_IND: begin
                            state_d = S_PH;
                            phase_d = '0;
                        end
                        S_PH: begin
                            if (bus.DONE) begin
                                seq_end   = 1'b1;
                                instr_end = 1'b1;
                            end else if (phase_q == PH_LAST) begin
                                // Last phase strobed with no handler finishing.
                                seq_err_d = 1'b1;
                                go_idle   = 1'b1;
                            end else begin
                                phase_d = phase_q + 1'b1;
                            end
                        end
                        S_BRK:   seq_end = 1'b1;
                        default: go_idle = 1'b1;
                    endcase
                end
            end
        endcase

        // Shared end-of-cycle priority for instruction end and break end.
        if (seq_end) begin
            if (stop_now || step_q) begin
                go_idle = 1'b1;
            end else if (bus.brk_req && (brk_cnt_q < BRK_LIM)) begin
                state_d   = S_BRK;
                brk_cnt_d = brk_cnt_q + 1'b1;
            end else begin
                state_d   = S_FETCH;
                brk_cnt_d = '0;
            end
        end

        if (go_idle) begin
            state_d    = S_IDLE;
            phase_d    = '0;
            half_d     = 1'b0;
            running_d  = 1'b0;
            stop_req_d = 1'b0;
            step_d     = 1'b0;
            brk_cnt_d  = '0;
        end
    end

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            half_q      <= 1'b0;
            running_q   <= 1'b0;
            stop_req_q  <= 1'b0;
            step_q      <= 1'b0;
            seq_err_q   <= 1'b0;
            brk_cnt_q   <= '0;
            startstop_q <= 1'b0;
            sst_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge, independent of statement order.
            state_q     <= state_d;
            phase_q     <= phase_d;
            half_q      <= half_d;
            running_q   <= running_d;
            stop_req_q  <= stop_req_d;
            step_q      <= step_d;
            seq_err_q   <= seq_err_d;
            brk_cnt_q   <= brk_cnt_d;
            startstop_q <= startstop_d;
            sst_q       <= sst_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decode of the registered state, so reset clears them
    // asynchronously and no strobe can glitch from an input.
    // -----------------------------------------------------------------------
    logic [NPHASE-1:0] ck_v;
    logic [NPHASE-1:0] stb_v;

    always_comb begin
        ck_v  = '0;
        stb_v = '0;
        if (state_q == S_PH) begin
            ck_v[phase_q]  = 1'b1;
            stb_v[phase_q] = half_q;
        end
    end

    assign bus.ck       = ck_v;
    assign bus.stb      = stb_v;
    assign bus.ckFetch  = (state_q == S_FETCH);
    assign bus.ckAuto1  = (state_q == S_AUTO1);
    assign bus.ckAuto2  = (state_q == S_AUTO2);
    assign bus.ckInd    = (state_q == S_IND);
    assign bus.ckBrk    = (state_q == S_BRK);
    assign bus.stbFetch = (state_q == S_FETCH) & half_q;
    assign bus.stbAuto1 = (state_q == S_AUTO1) & half_q;
    assign bus.stbAuto2 = (state_q == S_AUTO2) & half_q;
    assign bus.stbInd   = (state_q == S_IND)   & half_q;
    assign bus.stbBrk   = (state_q == S_BRK)   & half_q;
    assign bus.brk_ack  = (state_q == S_BRK)   & half_q;
    assign bus.running  = running_q;
    assign bus.seq_err  = seq_err_q;

    // -----------------------------------------------------------------------
    // Completed-instruction counter
    // -----------------------------------------------------------------------
`ifdef SEQ_ICOUNT_EN
    logic [CNT_W-1:0] icount_q, icount_d;

    always_comb begin
        icount_d = icount_q;
        if (instr_end) begin
            icount_d = icount_q + 1'b1;   // wraps naturally at 2^CNT_W
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            icount_q <= '0;
        end else begin
            icount_q <= icount_d;
        end
    end

    assign bus.icount = icount_q;
`else
    logic icount_unused;
    assign icount_unused = instr_end;
    assign bus.icount    = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pdp8_sequencer_gen.sv
// ---------------------------------------------------------------------------
// tb_pdp8_sequencer_gen
//
// Self-checking bench for pdp8_sequencer_gen (NPHASE=6, BRK_MAX=4, CNT_W=16).
// A cycle-by-cycle vector table covers start, the plain / auto-index /
// indirect sequences, HALT with DONE, overrun and restart. Hand-written
// sequences cover data breaks, stop during breaks, single step and reset in
// the middle of a phase.
// ---------------------------------------------------------------------------
module tb_pdp8_sequencer_gen;

    localparam int NPHASE  = 6;
    localparam int BRK_MAX = 4;
    localparam int CNT_W   = 16;
`ifdef SEQ_ICOUNT_EN
    localparam bit ICNT_ON = 1'b1;
`else
    localparam bit ICNT_ON = 1'b0;
`endif

    logic clk;
    logic rst_n;

    int n_cmp = 0;
    int n_bad = 0;

    pdp8_sequencer_gen_if #(.NPHASE(NPHASE), .CNT_W(CNT_W)) bus ();

    pdp8_sequencer_gen #(
        .NPHASE (NPHASE),
        .BRK_MAX(BRK_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .CLK  (clk),
        .RESET(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed output bundle: {named ck[5], named stb[5], ck[6], stb[6], brk_ack, running, seq_err}
    logic [24:0] obs_v;
    assign obs_v = {bus.ckFetch, bus.ckAuto1, bus.ckAuto2, bus.ckInd, bus.ckBrk,
                    bus.stbFetch, bus.stbAuto1, bus.stbAuto2, bus.stbInd, bus.stbBrk,
                    bus.ck, bus.stb, bus.brk_ack, bus.running, bus.seq_err};

    typedef enum int {E_IDLE, E_FETCH, E_AUTO1, E_AUTO2, E_IND, E_PH, E_BRK} est_e;

    typedef struct {
        logic       ss;
        logic       sst;
        logic       halt;
        logic       done;
        logic [1:0] seqt;
        logic       brk;
        est_e       st;
        int         ph;
        logic       hs;    // strobe clock of the state
        logic       run;
        logic       err;
    } vec_t;

    function automatic logic [24:0] exp_vec(input est_e st, input int ph,
                                            input logic hs, input logic run, input logic err);
        logic [4:0] n;
        logic [5:0] cv;
        n  = 5'b0;
        cv = 6'b0;
        case (st)
            E_FETCH: n = 5'b10000;
            E_AUTO1: n = 5'b01000;
            E_AUTO2: n = 5'b00100;
            E_IND:   n = 5'b00010;
            E_BRK:   n = 5'b00001;
            E_PH:    cv = 6'b000001 << ph;
            default: ;
        endcase
        return {n, (hs ? n : 5'b0), cv, (hs ? cv : 6'b0),
                (st == E_BRK) & hs, run, err};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ss, input logic sst, input logic halt,
                         input logic done, input logic [1:0] seqt, input logic brk);
        bus.startstop = ss;
        bus.sst       = sst;
        bus.HALT      = halt;
        bus.DONE      = done;
        bus.SEQTYPE   = seqt;
        bus.brk_req   = brk;
    endtask

    function automatic logic [31:0] icnt_exp(input int n);
        return ICNT_ON ? 32'(n) : 32'd0;
    endfunction

    vec_t tbl[38];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acks;
        int  brk_lv;
        logic saw_brk_late;

        // cycle: ss sst halt done seqt brk | state ph hs run err
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IDLE,  0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_FETCH, 0, 1'b0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_FETCH, 0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    0, 1'b0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, E_PH,    1, 1'b0, 1'b1, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    1, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    2, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, E_PH,    2, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_FETCH, 0, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, E_FETCH, 0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_AUTO1, 0, 1'b0, 1'b1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_AUTO1, 0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_AUTO2, 0, 1'b0, 1'b1, 1'b0};
        tbl[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_AUTO2, 0, 1'b1, 1'b1, 1'b0};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IND,   0, 1'b0, 1'b1, 1'b0};
        tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IND,   0, 1'b1, 1'b1, 1'b0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    0, 1'b0, 1'b1, 1'b0};
        tbl[18] = '{1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, E_PH,    0, 1'b1, 1'b1, 1'b0};
        tbl[19] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IDLE,  0, 1'b0, 1'b0, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_FETCH, 0, 1'b0, 1'b1, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, E_FETCH, 0, 1'b1, 1'b1, 1'b0};
        tbl[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IND,   0, 1'b0, 1'b1, 1'b0};
        tbl[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IND,   0, 1'b1, 1'b1, 1'b0};
        tbl[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    0, 1'b0, 1'b1, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    0, 1'b1, 1'b1, 1'b0};
        tbl[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    1, 1'b0, 1'b1, 1'b0};
        tbl[27] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    1, 1'b1, 1'b1, 1'b0};
        tbl[28] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    2, 1'b0, 1'b1, 1'b0};
        tbl[29] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    2, 1'b1, 1'b1, 1'b0};
        tbl[30] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    3, 1'b0, 1'b1, 1'b0};
        tbl[31] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    3, 1'b1, 1'b1, 1'b0};
        tbl[32] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    4, 1'b0, 1'b1, 1'b0};
        tbl[33] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    4, 1'b1, 1'b1, 1'b0};
        tbl[34] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    5, 1'b0, 1'b1, 1'b0};
        tbl[35] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_PH,    5, 1'b1, 1'b1, 1'b0};
        tbl[36] = '{1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_IDLE,  0, 1'b0, 1'b0, 1'b1};
        tbl[37] = '{1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, E_FETCH, 0, 1'b0, 1'b1, 1'b0};

        // ---------------- reset state ----------------
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        rst_n = 1'b0;
        #12;
        check("reset_outputs", 32'(obs_v), 32'd0);
        check("reset_icount", 32'(bus.icount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", 32'(obs_v), 32'd0);

        // ---------------- vector table ----------------
        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            drive(tbl[i].ss, tbl[i].sst, tbl[i].halt, tbl[i].done, tbl[i].seqt, tbl[i].brk);
            check($sformatf("vec[%0d]", i), 32'(obs_v),
                  32'(exp_vec(tbl[i].st, tbl[i].ph, tbl[i].hs, tbl[i].run, tbl[i].err)));
        end
        check("icount_after_table", 32'(bus.icount), icnt_exp(2));

        // ---------------- data breaks, then stop with brk_req still high ----------------
        // idx0 FETCH stb, 1-2 PH0 (DONE), 3-10 BRK x4, 11-12 FETCH, 13-14 PH0,
        // 15-22 BRK x4, 23-24 FETCH (stop pressed at 23), 25-26 PH0, 27 IDLE.
        acks = 0;
        brk_lv = 0;
        saw_brk_late = 1'b0;
        for (int idx = 0; idx < 29; idx++) begin
            @(negedge clk);
            drive((idx == 23), 1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
            if (bus.brk_ack) acks++;
            if (bus.ckBrk) brk_lv++;
            if (idx >= 23 && bus.ckBrk) saw_brk_late = 1'b1;
            if (idx == 3)  check("brk1_first_clock", 32'({bus.ckBrk, bus.brk_ack}), 32'b10);
            if (idx == 4)  check("brk1_ack_on_stb", 32'({bus.stbBrk, bus.brk_ack}), 32'b11);
            if (idx == 11) check("forced_fetch_1", 32'({bus.ckFetch, bus.ckBrk}), 32'b10);
            if (idx == 23) check("forced_fetch_2", 32'({bus.ckFetch, bus.ckBrk}), 32'b10);
            if (idx == 27) check("stop_to_idle", 32'(obs_v), 32'd0);
        end
        check("brk_ack_count", 32'(acks), 32'd8);
        check("brk_level_cycles", 32'(brk_lv), 32'd16);
        check("no_brk_while_stopping", 32'(saw_brk_late), 32'd0);
        check("icount_after_brk", 32'(bus.icount), icnt_exp(5));

        // ---------------- single step (sst while running is ignored) ----------------
        for (int idx = 0; idx < 9; idx++) begin
            @(negedge clk);
            drive(1'b0, (idx == 0) || (idx == 2), 1'b0, 1'b1, 2'b00, 1'b0);
            if (idx == 1) check("step_running", 32'({bus.ckFetch, bus.running}), 32'b11);
            if (idx == 4) check("step_ph0_stb", 32'(bus.stb), 32'b000001);
            if (idx == 5) check("step_idle", 32'(obs_v), 32'd0);
            if (idx == 8) check("step_stays_idle", 32'(obs_v), 32'd0);
        end
        check("icount_after_step", 32'(bus.icount), icnt_exp(6));

        // ---------------- reset in the middle of PH3 ----------------
        for (int idx = 0; idx < 10; idx++) begin
            @(negedge clk);
            drive((idx == 0), 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        end
        check("at_ph3", 32'({bus.ck, bus.stb, bus.running}), 32'({6'b001000, 6'b000000, 1'b1}));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 32'(obs_v), 32'd0);
        check("async_reset_icount", 32'(bus.icount), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int idx = 0; idx < 4; idx++) begin
            @(negedge clk);
            check($sformatf("post_reset_idle[%0d]", idx), 32'(obs_v), 32'd0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
        check("restart_fetch", 32'(obs_v), 32'(exp_vec(E_FETCH, 0, 1'b0, 1'b1, 1'b0)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pdp8_sequencer_gen.md
Name: pdp8_sequencer_gen

Overview:
- Parametrised major-state/timing generator for the PDP-8 CPU core; successor to the fixed six-phase sequencer.
- Drives the per-state clock-enable (ck*) and strobe (stb*) lines consumed by the fetch/indirect logic and the instruction handlers.
- Adds a configurable execute-phase count, a data-break (DMA) cycle with request/acknowledge handshake and starvation limit, and a phase-overrun error.

Parameters:
NPHASE, 6, number of execute phases (ck/stb width), 2..16
BRK_MAX, 4, max consecutive break cycles before a fetch is forced, 1..15
CNT_W, 16, width of instruction counter (optional feature)

Ports:
CLK  input  1  system clock
RESET  input  1  asynchronous active-low reset
startstop  input  1  run/stop button, rising-edge active
sst  input  1  single-step button, rising-edge active
HALT  input  1  halt request from OPR HLT
DONE  input  1  OR of handler done lines
SEQTYPE  input  2  {PPIND,IND} from IR decode
brk_req  input  1  data-break request, level
brk_ack  output  1  one-clock grant pulse
ckFetch,ckAuto1,ckAuto2,ckInd,ckBrk  output  1 each  state levels
stbFetch,stbAuto1,stbAuto2,stbInd,stbBrk  output  1 each  state strobes
ck  output  NPHASE  execute-phase levels, one-hot
stb  output  NPHASE  execute-phase strobes, one-hot
running  output  1  CPU running
seq_err  output  1  sticky phase-overrun flag
icount  output  CNT_W  completed-instruction count (optional feature)

Behaviour:
- Async reset (RESET=0): state IDLE; every output 0; edge detectors cleared; stop_req, step and brk counter cleared. Reset mid-state aborts the state with no further strobes.
- States: IDLE, FETCH, AUTO1, AUTO2, IND, PH[0..NPHASE-1], BRK.
- Every non-IDLE state lasts exactly 2 clocks:
  - ck<state> high on both clocks.
  - stb<state> high on the 2nd clock only.
  - At most one ck and one stb are high at any time.
- Start: startstop rising edge in IDLE sets running=1; FETCH begins next clock. Clears seq_err.
- Single step: sst rising edge in IDLE sets running=1 and step=1; exactly one instruction runs, then IDLE with running=0.
- Stop: startstop edge while running sets stop_req. The current instruction completes, then IDLE with running=0. No breaks are granted while stop_req is set.
- SEQTYPE is sampled on the stbFetch clock:
  - 00 → PH0
  - 01 → IND → PH0
  - 1x → AUTO1 → AUTO2 → IND → PH0
- DONE is honoured only on a stb[k] clock (any k). Otherwise it is ignored.
- DONE on stb[k] → instruction end. Otherwise PH[k] → PH[k+1].
- Overrun: stb[NPHASE-1] without DONE → seq_err=1 (sticky), running=0, IDLE.
- HALT is sampled on any PH clock and sets stop_req. HALT and DONE on the same clock → instruction ends, then IDLE.
- Instruction end, priority order:
  1. stop_req or step → IDLE, running=0, flags cleared.
  2. brk_req=1 and brk_cnt<BRK_MAX → BRK, brk_cnt+1.
  3. Otherwise → FETCH, brk_cnt=0.
- BRK: brk_ack pulses with stbBrk. At the end of BRK the same priority check is repeated. brk_cnt==BRK_MAX forces FETCH.
- brk_req dropped before the BRK stb clock: the BRK still completes and brk_ack still pulses. The requester ignores an unwanted ack.
- startstop and sst edges are detected every clock. An sst edge while running is ignored.

Optional Feature:
- Macro SEQ_ICOUNT_EN.
- Defined: icount increments (modulo 2^CNT_W, wrap to 0) on each instruction end, including a HALT end. It does not increment on overrun or BRK, and resets to 0.
- Undefined: icount tied to 0 and no counter logic is built.

Test Plan:
- NPHASE=6, SEQTYPE=00, startstop pulse, DONE on stb[2] → FETCH,PH0,PH1,PH2 at 2 clocks each, then FETCH again; running=1.
- SEQTYPE=10 → ckAuto1,ckAuto2,ckInd each 2 clocks before ck[0]; each stb on the 2nd clock only.
- DONE never asserted → seq_err=1 after stb[5], running=0, IDLE. A later startstop clears seq_err.
- brk_req held high, BRK_MAX=4 → exactly 4 BRK states with 4 brk_ack pulses, then a forced FETCH, then 4 more after the next instruction.
- sst pulse in IDLE, DONE on stb[0] → one instruction only, then running=0. With SEQ_ICOUNT_EN, icount goes 0→1.
- Reset asserted during PH3 → all outputs 0 asynchronously. After release the block stays IDLE until a startstop edge.
